ext_mem_arbiter: RTL

EXT_MEM_ARBITER -- requirements
Module: ext_mem_arbiter

---
 rtl/ext_mem_arbiter_if.sv | 34 +++
 rtl/ext_mem_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ext_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ext_mem_arbiter_if
// Brief    : Core-side request/response and external-bus signals of the arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface ext_mem_arbiter_if;
  logic        pm_req;
  logic [15:0] pm_add;
  logic        dm_req;
  logic [15:0] dm_add;
  logic        wrb;
  logic [15:0] dm_wdata;
  logic [15:0] ext_rdata;
  logic        ext_rdy;
  logic [15:0] ext_add;
  logic [15:0] ext_wdata;
  logic        ext_rd;
  logic        ext_wr;
  logic [15:0] pm_rdata;
  logic [15:0] dm_rdata;
  logic        stall;

  modport slave (
    input  pm_req, pm_add, dm_req, dm_add, wrb, dm_wdata, ext_rdata, ext_rdy,
    output ext_add, ext_wdata, ext_rd, ext_wr, pm_rdata, dm_rdata, stall
  );

  modport master (
    output pm_req, pm_add, dm_req, dm_add, wrb, dm_wdata, ext_rdata, ext_rdy,
    input  ext_add, ext_wdata, ext_rd, ext_wr, pm_rdata, dm_rdata, stall
  );
endinterface
`default_nettype wire

// File: rtl/ext_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ext_mem_arbiter
// Brief    : Arbitrates program/data fetches onto one wait-stated external bus
// Revision : 1.0 - initial release
// ============================================================================
module ext_mem_arbiter #(
  parameter logic [3:0] WAIT_STATES = 4'd2
) (
  input wire             clk,
  input wire             rst,
  ext_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DM_ACC = 2'd1,
    S_PM_ACC = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait_cnt;
  logic        r_pm_pend;
  logic [15:0] r_ext_add;
  logic [15:0] r_ext_wdata;
  logic        r_ext_rd;
  logic        r_ext_wr;
  logic [15:0] r_pm_rdata;
  logic [15:0] r_dm_rdata;

  logic w_dm_ext;
  logic w_pm_ext;
  logic w_acc_done;
  logic w_load_dm;
  logic w_load_pm;
  logic w_stall;

  // Addresses with a nonzero top nibble live off-chip.
  assign w_dm_ext   = bus.dm_req & (bus.dm_add[15:12] != 4'h0);
  assign w_pm_ext   = bus.pm_req & (bus.pm_add[15:12] != 4'h0);
  assign w_acc_done = (r_wait_cnt == 4'd0) & bus.ext_rdy;

  always_comb begin
    w_state_nxt = r_state;
    w_load_dm   = 1'b0;
    w_load_pm   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dm_ext) begin
          w_state_nxt = S_DM_ACC;
          w_load_dm   = 1'b1;
        end else if (w_pm_ext) begin
          w_state_nxt = S_PM_ACC;
          w_load_pm   = 1'b1;
        end
      end
      S_DM_ACC: begin
        if (w_acc_done) begin
          if (r_pm_pend) begin
            w_state_nxt = S_PM_ACC;
            w_load_pm   = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_PM_ACC: begin
        if (w_acc_done) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_stall = 1'b1;
    if (rst) begin
      w_stall = 1'b1;
    end else if ((r_state == S_DM_ACC) || (r_state == S_PM_ACC)) begin
      w_stall = 1'b0;
    end else if ((r_state == S_IDLE) && (w_dm_ext || w_pm_ext)) begin
      w_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 4'd0;
      r_pm_pend   <= 1'b0;
      r_ext_add   <= 16'h0000;
      r_ext_wdata <= 16'h0000;
      r_ext_rd    <= 1'b0;
      r_ext_wr    <= 1'b0;
      r_pm_rdata  <= 16'h0000;
      r_dm_rdata  <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;

      if (w_load_dm) begin
        r_wait_cnt  <= WAIT_STATES;
        r_pm_pend   <= w_pm_ext;
        r_ext_add   <= bus.dm_add;
        r_ext_wdata <= bus.dm_wdata;
        r_ext_rd    <= ~bus.wrb;
        r_ext_wr    <= bus.wrb;
      end else if (w_load_pm) begin
        r_wait_cnt  <= WAIT_STATES;
        r_pm_pend   <= 1'b0;
        r_ext_add   <= bus.pm_add;
        r_ext_wdata <= 16'h0000;
        r_ext_rd    <= 1'b1;
        r_ext_wr    <= 1'b0;
      end else begin
        if ((w_state_nxt == S_DONE) || (w_state_nxt == S_IDLE)) begin
          r_ext_add   <= 16'h0000;
          r_ext_wdata <= 16'h0000;
          r_ext_rd    <= 1'b0;
          r_ext_wr    <= 1'b0;
          r_pm_pend   <= 1'b0;
        end
        if (r_wait_cnt != 4'd0) begin
          r_wait_cnt <= r_wait_cnt - 4'd1;
        end
      end

      // Write completions leave dm_rdata untouched.
      if ((r_state == S_DM_ACC) && w_acc_done && !r_ext_wr) begin
        r_dm_rdata <= bus.ext_rdata;
      end
      if ((r_state == S_PM_ACC) && w_acc_done) begin
        r_pm_rdata <= bus.ext_rdata;
      end
    end
  end

  assign bus.ext_add   = r_ext_add;
  assign bus.ext_wdata = r_ext_wdata;
  assign bus.ext_rd    = r_ext_rd;
  assign bus.ext_wr    = r_ext_wr;
  assign bus.pm_rdata  = r_pm_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.stall     = w_stall;

endmodule
`default_nettype wire
